// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Brief    : Shares the SDRAM controller command interface between two
//            requesters. Every access runs ACTIVATE -> READ/WRITE with
//            auto-precharge, and periodic AUTO REFRESH is inserted.
//            Build option SDRAM_ARBITER_FIXED_PRIORITY_EN: port 0 always wins
//            simultaneous requests (no round-robin pointer).
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter logic [2:0]  CMD_ACTIVATE            = 3'b011,
    parameter logic [2:0]  CMD_READ                = 3'b101,
    parameter logic [2:0]  CMD_WRITE               = 3'b100,
    parameter logic [2:0]  CMD_REFRESH             = 3'b001,
    parameter int unsigned ACTIVATE_WAIT_CYCLES    = 2,
    parameter int unsigned READ_LATENCY_CYCLES     = 4,
    parameter int unsigned RECOVERY_CYCLES         = 3,
    parameter int unsigned REFRESH_INTERVAL_CYCLES = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_write,
    input  logic [20:0] p0_address,
    input  logic [31:0] p0_data,
    input  logic [3:0]  p0_dqm,
    output logic [31:0] p0_rd_data,
    output logic        p0_done,
    input  logic        p1_req,
    input  logic        p1_write,
    input  logic [20:0] p1_address,
    input  logic [31:0] p1_data,
    input  logic [3:0]  p1_dqm,
    output logic [31:0] p1_rd_data,
    output logic        p1_done,
    input  logic        O_sdrc_init_done,
    input  logic        O_sdrc_cmd_ack,
    input  logic [31:0] O_sdrc_data,
    output logic        I_sdrc_cmd_en,
    output logic [2:0]  I_sdrc_cmd,
    output logic        I_sdrc_precharge_ctrl,
    output logic [20:0] I_sdrc_addr,
    output logic [3:0]  I_sdrc_dqm,
    output logic [31:0] I_sdrc_data,
    output logic [7:0]  I_sdrc_data_len,
    output logic        I_sdram_power_down,
    output logic        I_sdram_selfrefresh,
    output logic        busy
);

    localparam logic [3:0] c_st_wait_init = 4'd0;
    localparam logic [3:0] c_st_idle      = 4'd1;
    localparam logic [3:0] c_st_activate  = 4'd2;
    localparam logic [3:0] c_st_act_wait  = 4'd3;
    localparam logic [3:0] c_st_access    = 4'd4;
    localparam logic [3:0] c_st_read_wait = 4'd5;
    localparam logic [3:0] c_st_recover   = 4'd6;
    localparam logic [3:0] c_st_refresh   = 4'd7;

    localparam int unsigned c_ref_w = $clog2(REFRESH_INTERVAL_CYCLES);
    localparam logic [c_ref_w-1:0] c_ref_last = c_ref_w'(REFRESH_INTERVAL_CYCLES - 1);
    localparam logic [3:0] c_act_last = 4'(ACTIVATE_WAIT_CYCLES - 1);
    localparam logic [3:0] c_rd_last  = 4'(READ_LATENCY_CYCLES - 1);
    localparam logic [3:0] c_rec_last = 4'(RECOVERY_CYCLES - 1);

    logic [3:0]         r_state;
    logic [3:0]         r_wait_cnt;
    logic [c_ref_w-1:0] r_ref_cnt;
    logic               r_ref_run;
    logic               r_ref_pending;

    logic               r_port;
    logic               r_write;
    logic [20:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wdqm;

    logic               r_cmd_en;
    logic [2:0]         r_cmd;
    logic               r_prech;
    logic [20:0]        r_addr_out;
    logic [3:0]         r_dqm_out;
    logic [31:0]        r_data_out;
    logic [31:0]        r_p0_rd;
    logic [31:0]        r_p1_rd;
    logic               r_p0_done;
    logic               r_p1_done;
    logic               r_busy;

    logic               w_grant_port;

`ifdef SDRAM_ARBITER_FIXED_PRIORITY_EN
    assign w_grant_port = !p0_req;
`else
    // r_rr_next names the port that wins the next simultaneous request
    logic               r_rr_next;
    assign w_grant_port = (p0_req && p1_req) ? r_rr_next : p1_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_st_wait_init;
            r_wait_cnt    <= 4'd0;
            r_ref_cnt     <= '0;
            r_ref_run     <= 1'b0;
            r_ref_pending <= 1'b0;
            r_port        <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= 21'd0;
            r_wdata       <= 32'd0;
            r_wdqm        <= 4'd0;
            r_cmd_en      <= 1'b0;
            r_cmd         <= 3'd0;
            r_prech       <= 1'b0;
            r_addr_out    <= 21'd0;
            r_dqm_out     <= 4'd0;
            r_data_out    <= 32'd0;
            r_p0_rd       <= 32'd0;
            r_p1_rd       <= 32'd0;
            r_p0_done     <= 1'b0;
            r_p1_done     <= 1'b0;
            r_busy        <= 1'b0;
`ifndef SDRAM_ARBITER_FIXED_PRIORITY_EN
            r_rr_next     <= 1'b0;
`endif
        end else begin
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;

            case (r_state)
                c_st_wait_init: begin
                    r_busy <= !O_sdrc_init_done;
                    if (O_sdrc_init_done) begin
                        r_state <= c_st_idle;
                    end
                end

                c_st_idle: begin
                    if (r_ref_pending) begin
                        r_state    <= c_st_refresh;
                        r_cmd_en   <= 1'b1;
                        r_cmd      <= CMD_REFRESH;
                        r_addr_out <= 21'd0;
                        r_busy     <= 1'b1;
                    end else if (p0_req || p1_req) begin
                        r_state    <= c_st_activate;
                        r_port     <= w_grant_port;
                        r_write    <= w_grant_port ? p1_write   : p0_write;
                        r_addr     <= w_grant_port ? p1_address : p0_address;
                        r_wdata    <= w_grant_port ? p1_data    : p0_data;
                        r_wdqm     <= w_grant_port ? p1_dqm     : p0_dqm;
                        r_cmd_en   <= 1'b1;
                        r_cmd      <= CMD_ACTIVATE;
                        r_addr_out <= w_grant_port ? p1_address : p0_address;
                        r_busy     <= 1'b1;
                    end
                end

                c_st_activate: begin
                    if (O_sdrc_cmd_ack) begin
                        r_cmd_en   <= 1'b0;
                        r_wait_cnt <= 4'd0;
                        r_state    <= c_st_act_wait;
                    end
                end

                c_st_act_wait: begin
                    if (r_wait_cnt == c_act_last) begin
                        r_state    <= c_st_access;
                        r_cmd_en   <= 1'b1;
                        r_cmd      <= r_write ? CMD_WRITE : CMD_READ;
                        r_prech    <= 1'b1;
                        r_addr_out <= r_addr;
                        r_dqm_out  <= r_write ? r_wdqm  : 4'd0;
                        r_data_out <= r_write ? r_wdata : 32'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end

                c_st_access: begin
                    if (O_sdrc_cmd_ack) begin
                        r_cmd_en   <= 1'b0;
                        r_prech    <= 1'b0;
                        r_dqm_out  <= 4'd0;
                        r_data_out <= 32'd0;
                        r_wait_cnt <= 4'd0;
                        if (r_write) begin
                            r_state   <= c_st_recover;
                            r_p0_done <= !r_port;
                            r_p1_done <= r_port;
`ifndef SDRAM_ARBITER_FIXED_PRIORITY_EN
                            r_rr_next <= !r_port;
`endif
                        end else begin
                            r_state <= c_st_read_wait;
                        end
                    end
                end

                c_st_read_wait: begin
                    if (r_wait_cnt == c_rd_last) begin
                        if (r_port) begin
                            r_p1_rd <= O_sdrc_data;
                        end else begin
                            r_p0_rd <= O_sdrc_data;
                        end
                        r_state    <= c_st_recover;
                        r_wait_cnt <= 4'd0;
                        r_p0_done  <= !r_port;
                        r_p1_done  <= r_port;
`ifndef SDRAM_ARBITER_FIXED_PRIORITY_EN
                        r_rr_next  <= !r_port;
`endif
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end

                c_st_recover: begin
                    if (r_wait_cnt == c_rec_last) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end

                c_st_refresh: begin
                    if (O_sdrc_cmd_ack) begin
                        r_cmd_en      <= 1'b0;
                        r_ref_pending <= 1'b0;
                        r_wait_cnt    <= 4'd0;
                        r_state       <= c_st_recover;
                    end
                end

                default: begin
                    r_state <= c_st_wait_init;
                end
            endcase

            // Placed after the FSM so a wrap coinciding with a refresh ack re-arms pending
            if (r_ref_run || O_sdrc_init_done) begin
                r_ref_run <= 1'b1;
                if (r_ref_cnt == c_ref_last) begin
                    r_ref_cnt     <= '0;
                    r_ref_pending <= 1'b1;
                end else begin
                    r_ref_cnt <= r_ref_cnt + 1'b1;
                end
            end
        end
    end

    assign I_sdrc_cmd_en         = r_cmd_en;
    assign I_sdrc_cmd            = r_cmd;
    assign I_sdrc_precharge_ctrl = r_prech;
    assign I_sdrc_addr           = r_addr_out;
    assign I_sdrc_dqm            = r_dqm_out;
    assign I_sdrc_data           = r_data_out;
    assign I_sdrc_data_len       = 8'd0;
    assign I_sdram_power_down    = 1'b0;
    assign I_sdram_selfrefresh   = 1'b0;
    assign p0_rd_data            = r_p0_rd;
    assign p1_rd_data            = r_p1_rd;
    assign p0_done               = r_p0_done;
    assign p1_done               = r_p1_done;
    assign busy                  = r_busy;

endmodule
`default_nettype wire
